imem_boot_loader: RTL and testbench

// Writer side of the if_stage instruction-memory port (wdata_i/wen_i): accepts a byte stream,

---
 rtl/imem_boot_loader_pkg.sv | 16 +
 rtl/imem_boot_loader_byte_packer.sv | 52 +++++
 rtl/imem_boot_loader.sv | 135 +++++++++++++
 tb/tb_imem_boot_loader.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Default geometry matches the core's instruction memory; the top exposes it as parameters.
package imem_boot_loader_pkg;

    localparam int CORE_ADDR_WIDTH = 10;
    localparam int CORE_DATA_WIDTH = 32;
    localparam int DATA_BYTES      = CORE_DATA_WIDTH / 8;
    localparam int LOADER_BYTES    = DATA_BYTES;

    typedef enum logic [1:0] {
        LD_LOAD,
        LD_DONE,
        LD_ERR
    } loader_state_t;

endpackage

// File: rtl/imem_boot_loader_byte_packer.sv
// Assembles an incoming byte stream little-endian into memory words.
// The write strobe, word and byte-enable mask are combinational on the completing byte.
module imem_boot_loader_byte_packer
    import imem_boot_loader_pkg::*;
#(
    parameter int BYTES = LOADER_BYTES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 byte_valid,
    input  logic [7:0]           byte_data,
    input  logic                 byte_last,
    output logic                 wr_o,
    output logic [8*BYTES-1:0]   word_o,
    output logic [BYTES-1:0]     mask_o
);

    localparam int LANE_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    logic [LANE_W-1:0]  lane_q;
    logic [8*BYTES-1:0] asm_q;
    logic [8*BYTES-1:0] asm_d;

    always_comb begin
        asm_d = asm_q;
        asm_d[8*lane_q +: 8] = byte_data;
        mask_o = '0;
        for (int i = 0; i < BYTES; i++) begin
            mask_o[i] = (i <= int'(lane_q));
        end
        word_o = asm_d;
        wr_o   = byte_valid && (byte_last || (lane_q == LANE_W'(BYTES - 1)));
    end

    // Lanes above the newest byte stay zero because the register clears after every write.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            lane_q <= '0;
            asm_q  <= '0;
        end else if (byte_valid) begin
            if (wr_o) begin
                lane_q <= '0;
                asm_q  <= '0;
            end else begin
                lane_q <= lane_q + 1'b1;
                asm_q  <= asm_d;
            end
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: streams an image into instruction memory and holds the core in reset until it is complete.
// Handshake: a byte transfers on a rising edge where s_valid_i and s_ready_o are both high; s_ready_o is a pure function of registered state.
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = CORE_ADDR_WIDTH,
    parameter int DEPTH      = 1 << ADDR_WIDTH,
    parameter int DATA_WIDTH = CORE_DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic                    s_valid_i,
    input  logic [7:0]              s_data_i,
    input  logic                    s_last_i,
    output logic                    s_ready_o,
    output logic [ADDR_WIDTH-1:0]   waddr_o,
    output logic [DATA_WIDTH-1:0]   wdata_o,
    output logic [DATA_WIDTH/8-1:0] wen_o,
    output logic                    core_rst_o,
    output logic                    load_done_o,
    output logic                    err_o,
    output logic [ADDR_WIDTH:0]     word_cnt_o,
    output logic [31:0]             checksum_o
);

    localparam int                  BYTES     = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0] DEPTH_IDX = (ADDR_WIDTH + 1)'(DEPTH);

    loader_state_t         state_q;
    loader_state_t         state_d;
    logic                  armed_q;
    logic                  fin_q;
    logic [ADDR_WIDTH:0]   index_q;

    logic                  accept;
    logic                  overflow;
    logic                  pk_valid;
    logic                  finish;
    logic                  restart;
    logic                  pk_wr;
    logic [DATA_WIDTH-1:0] pk_word;
    logic [BYTES-1:0]      pk_mask;

    imem_boot_loader_byte_packer #(
        .BYTES(BYTES)
    ) u_packer (
        .clk        (clk),
        .rst        (rst),
        .flush      (restart),
        .byte_valid (pk_valid),
        .byte_data  (s_data_i),
        .byte_last  (s_last_i),
        .wr_o       (pk_wr),
        .word_o     (pk_word),
        .mask_o     (pk_mask)
    );

    // fin_q covers the cycle between the final write and the DONE transition, so no byte slips in.
    always_comb begin
        state_d   = state_q;
        finish    = 1'b0;
        restart   = 1'b0;
        s_ready_o = armed_q && (state_q == LD_LOAD) && !fin_q;
        accept    = s_valid_i && s_ready_o;
        overflow  = accept && (index_q == DEPTH_IDX);
        pk_valid  = accept && !overflow;
        case (state_q)
            LD_LOAD: begin
                if (overflow) begin
                    state_d = LD_ERR;
                end else if (fin_q) begin
                    state_d = LD_DONE;
                    finish  = 1'b1;
                end
            end
            LD_DONE, LD_ERR: begin
                if (start_i) begin
                    state_d = LD_LOAD;
                    restart = 1'b1;
                end
            end
            default: state_d = LD_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= LD_LOAD;
            armed_q     <= 1'b0;
            fin_q       <= 1'b0;
            index_q     <= '0;
            waddr_o     <= '0;
            wdata_o     <= '0;
            wen_o       <= '0;
            core_rst_o  <= 1'b0;
            load_done_o <= 1'b0;
            err_o       <= 1'b0;
            word_cnt_o  <= '0;
            checksum_o  <= '0;
        end else begin
            state_q <= state_d;
            armed_q <= 1'b1;
            wen_o   <= pk_wr ? pk_mask : '0;
            if (pk_wr) begin
                waddr_o    <= index_q[ADDR_WIDTH-1:0];
                wdata_o    <= pk_word;
                index_q    <= index_q + 1'b1;
                word_cnt_o <= word_cnt_o + 1'b1;
                checksum_o <= checksum_o + 32'(pk_word);
            end
            if (pk_valid && s_last_i) begin
                fin_q <= 1'b1;
            end else if (finish) begin
                fin_q <= 1'b0;
            end
            if (finish) begin
                core_rst_o  <= 1'b1;
                load_done_o <= 1'b1;
            end
            if (overflow) begin
                err_o <= 1'b1;
            end
            if (restart) begin
                core_rst_o  <= 1'b0;
                load_done_o <= 1'b0;
                err_o       <= 1'b0;
                word_cnt_o  <= '0;
                checksum_o  <= '0;
                index_q     <= '0;
            end
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomized bench for imem_boot_loader with a 4-word memory; writes are scoreboarded against an image model.
module tb_imem_boot_loader;

    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;
    localparam int W     = AW + 32 + 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start_i = 1'b0;
    logic          s_valid_i = 1'b0;
    logic [7:0]    s_data_i = '0;
    logic          s_last_i = 1'b0;
    logic          s_ready_o;
    logic [AW-1:0] waddr_o;
    logic [31:0]   wdata_o;
    logic [3:0]    wen_o;
    logic          core_rst_o;
    logic          load_done_o;
    logic          err_o;
    logic [AW:0]   word_cnt_o;
    logic [31:0]   checksum_o;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];

    // Image model: bytes of the word in progress, words written, running sum, terminal flags.
    logic [7:0]  cur[$];
    int          m_idx;
    logic [31:0] m_sum;
    bit          m_done;
    bit          m_err;

    imem_boot_loader #(
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH),
        .DATA_WIDTH (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .s_valid_i   (s_valid_i),
        .s_data_i    (s_data_i),
        .s_last_i    (s_last_i),
        .s_ready_o   (s_ready_o),
        .waddr_o     (waddr_o),
        .wdata_o     (wdata_o),
        .wen_o       (wen_o),
        .core_rst_o  (core_rst_o),
        .load_done_o (load_done_o),
        .err_o       (err_o),
        .word_cnt_o  (word_cnt_o),
        .checksum_o  (checksum_o)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        cur.delete();
        m_idx  = 0;
        m_sum  = '0;
        m_done = 1'b0;
        m_err  = 1'b0;
    endtask

    task automatic model_byte(input logic [7:0] d, input bit last);
        logic [31:0] w;
        logic [3:0]  m;
        if (m_idx == DEPTH) begin
            m_err = 1'b1;
            return;
        end
        cur.push_back(d);
        if (cur.size() == 4 || last) begin
            w = '0;
            m = '0;
            for (int i = 0; i < cur.size(); i++) begin
                w = w + (32'(cur[i]) << (8 * i));
                m[i] = 1'b1;
            end
            exp_q.push_back({AW'(m_idx), w, m});
            m_sum = m_sum + w;
            m_idx++;
            cur.delete();
            if (last) m_done = 1'b1;
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (wen_o != 4'h0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write_wen", {60'h0, wen_o}, 64'h0);
            end else begin
                e = exp_q.pop_front();
                check("write_addr", 64'(waddr_o), 64'(e[W-1 -: AW]));
                check("write_data", 64'(wdata_o), 64'(e[35:4]));
                check("write_wen",  64'(wen_o),   64'(e[3:0]));
            end
        end
    end

    // drivers
    task automatic send_byte(input logic [7:0] d, input bit last);
        bit acc;
        bit exp_acc;
        @(negedge clk);
        s_valid_i = 1'b1;
        s_data_i  = d;
        s_last_i  = last;
        acc       = s_ready_o;
        exp_acc   = !(m_done || m_err);
        check("s_ready_at_byte", 64'(acc), 64'(exp_acc));
        if (exp_acc) model_byte(d, last);
        @(posedge clk);
        #1;
        s_valid_i = 1'b0;
        s_last_i  = 1'b0;
    endtask

    task automatic check_status(input string tag);
        check({tag, "_core_rst"},  64'(core_rst_o),  64'(m_done));
        check({tag, "_load_done"}, 64'(load_done_o), 64'(m_done));
        check({tag, "_err"},       64'(err_o),       64'(m_err));
        check({tag, "_word_cnt"},  64'(word_cnt_o),  64'(m_idx));
        check({tag, "_checksum"},  64'(checksum_o),  64'(m_sum));
        check({tag, "_s_ready"},   64'(s_ready_o),   64'(!(m_done || m_err)));
    endtask

    task automatic settle();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst       = 1'b0;
        s_valid_i = 1'b0;
        s_last_i  = 1'b0;
        start_i   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_s_ready",  64'(s_ready_o),   64'h0);
        check("rst_waddr",    64'(waddr_o),     64'h0);
        check("rst_wdata",    64'(wdata_o),     64'h0);
        check("rst_wen",      64'(wen_o),       64'h0);
        check("rst_core_rst", 64'(core_rst_o),  64'h0);
        check("rst_done",     64'(load_done_o), 64'h0);
        check("rst_err",      64'(err_o),       64'h0);
        check("rst_word_cnt", 64'(word_cnt_o),  64'h0);
        check("rst_checksum", 64'(checksum_o),  64'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_release", 64'(s_ready_o), 64'h1);
    endtask

    task automatic do_start();
        @(negedge clk);
        start_i   = 1'b1;
        s_valid_i = 1'b0;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        model_reset();
        check_status("after_start");
    endtask

    initial begin
        int n;
        logic [7:0] img[$];

        // Reset only: core stays held while idle.
        apply_reset();
        repeat (5) @(posedge clk);
        #1;
        check("idle_core_rst", 64'(core_rst_o), 64'h0);
        check_status("idle");

        // One full word; core release lands two edges after the last byte.
        img = '{8'h13, 8'h05, 8'h00, 8'h00};
        for (int i = 0; i < 4; i++) send_byte(img[i], i == 3);
        check("release_not_early", 64'(core_rst_o), 64'h0);
        @(posedge clk);
        #1;
        check("release_on_time", 64'(core_rst_o), 64'h1);
        check("checksum_513",    64'(checksum_o), 64'h513);
        check_status("img1");

        // Six bytes: a full word then a two-lane partial word.
        do_start();
        for (int i = 1; i <= 6; i++) send_byte(8'(i), i == 6);
        settle();
        check("checksum_six", 64'(checksum_o), 64'h04030806);
        check_status("img2");

        // 17 bytes into 4 words: the 17th overflows.
        do_start();
        for (int i = 0; i < 17; i++) send_byte(8'($urandom_range(0, 255)), 1'b0);
        settle();
        check("overflow_err", 64'(err_o), 64'h1);
        check_status("overflow");
        send_byte(8'hAA, 1'b1);
        settle();
        check_status("overflow_hold");
        do_start();

        // Reset in the middle of a word discards the partial bytes.
        send_byte(8'hDE, 1'b0);
        send_byte(8'hAD, 1'b0);
        apply_reset();
        img = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) send_byte(img[i], i == 3);
        settle();
        check_status("reload");

        // Valid held in DONE must not write; start releases back to LOAD.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            s_valid_i = 1'b1;
            s_data_i  = 8'($urandom_range(0, 255));
            s_last_i  = 1'(i[0]);
            check("done_ignores_valid", 64'(s_ready_o), 64'h0);
        end
        do_start();
        check("start_drops_core_rst", 64'(core_rst_o), 64'h0);

        // Random images, random gaps, occasional start pulse in LOAD (ignored).
        for (int img_n = 0; img_n < 12; img_n++) begin
            if (m_done || m_err) do_start();
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                start_i = 1'b1;
                @(posedge clk);
                #1;
                start_i = 1'b0;
            end
            n = $urandom_range(1, 18);
            for (int i = 0; i < n; i++) begin
                repeat ($urandom_range(0, 2)) @(posedge clk);
                send_byte(8'($urandom_range(0, 255)), i == n - 1);
            end
            settle();
            check_status("rand");
        end

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(exp_q.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
